// File: rtl/spi_pkg.sv
// Shared constants and SPI mode decode helpers for the SPI peripheral.
package spi_pkg;

  localparam int unsigned ByteW = 8;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StActive = 1'b1;

  function automatic logic mode_cpol(input int unsigned mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic mode_cpha(input int unsigned mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous bit, with a configurable reset level.
module spi_sync #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI target: oversamples SCLK/CS/MOSI on i_Clk, MSB-first bytes, 1-entry TX holding register.
module spi_peripheral
  import spi_pkg::*;
#(
  parameter int unsigned SPI_MODE = 0
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic [ByteW-1:0] i_TX_Byte,
  input  logic             i_TX_DV,
  output logic             o_TX_Ready,
  output logic             o_RX_DV,
  output logic [ByteW-1:0] o_RX_Byte,
  output logic             o_TX_Underrun,
  input  logic             i_SPI_Clk,
  input  logic             i_SPI_CS_n,
  input  logic             i_SPI_MOSI,
  output logic             o_SPI_MISO,
  output logic             o_SPI_MISO_En
);

  localparam logic Cpol = mode_cpol(SPI_MODE);
  localparam logic Cpha = mode_cpha(SPI_MODE);

  logic sclk_s, cs_s, mosi_s;

  spi_sync #(.ResetVal(Cpol)) u_sync_sclk (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .d_i    (i_SPI_Clk),
    .q_o    (sclk_s)
  );

  spi_sync #(.ResetVal(1'b1)) u_sync_cs (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .d_i    (i_SPI_CS_n),
    .q_o    (cs_s)
  );

  spi_sync #(.ResetVal(1'b0)) u_sync_mosi (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .d_i    (i_SPI_MOSI),
    .q_o    (mosi_s)
  );

  logic [0:0]       state_q, state_d;
  logic [1:0]       settle_q, settle_d;
  logic             armed_q, armed_d;
  logic             sclk_prev_q;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0] rx_shift_q, rx_shift_d;
  logic [ByteW-1:0] rx_byte_q, rx_byte_d;
  logic             rx_dv_q, rx_dv_d;
  logic [ByteW-1:0] tx_shift_q, tx_shift_d;
  logic [ByteW-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             underrun_q, underrun_d;

  logic active, cs_fall, cs_rise, leading, trailing, sample, shift, load;

  // armed_q only sets once CS has been seen high after reset, so a CS held low
  // across reset release does not restart a transfer.
  assign active   = (state_q == StActive);
  assign cs_fall  = !active && armed_q && !cs_s;
  assign cs_rise  = active && cs_s;
  assign leading  = active && !cs_s && (sclk_prev_q == Cpol) && (sclk_s != Cpol);
  assign trailing = active && !cs_s && (sclk_prev_q != Cpol) && (sclk_s == Cpol);
  assign sample   = Cpha ? trailing : leading;
  assign shift    = Cpha ? leading : trailing;
  // A shift edge with the counter at 0 is always the first shift of a byte.
  assign load     = (!Cpha && cs_fall) || (shift && (bit_cnt_q == 3'd0));

  always_comb begin
    state_d     = state_q;
    settle_d    = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | ((settle_q == 2'd2) && cs_s);
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;

    if (cs_fall) begin
      state_d = StActive;
    end else if (cs_rise) begin
      state_d    = StIdle;
      bit_cnt_d  = 3'd0;
      rx_shift_d = '0;
    end

    if (sample) begin
      rx_shift_d = {rx_shift_q[ByteW-2:0], mosi_s};
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_dv_d   = 1'b1;
        rx_byte_d = {rx_shift_q[ByteW-2:0], mosi_s};
      end
    end

    if (load) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = '1;
        underrun_d = 1'b1;
      end
      hold_full_d = 1'b0;
    end else if (shift) begin
      tx_shift_d = {tx_shift_q[ByteW-2:0], 1'b0};
    end

    // A new byte coinciding with a load lands after the old one moved out.
    if (i_TX_DV && (!hold_full_q || load)) begin
      hold_d      = i_TX_Byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      sclk_prev_q <= Cpol;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_dv_q     <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      sclk_prev_q <= sclk_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_TX_Ready    = !hold_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_TX_Underrun = underrun_q;
  assign o_SPI_MISO    = tx_shift_q[ByteW-1];
  assign o_SPI_MISO_En = active;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench: one spi_peripheral per SPI mode, driven by a behavioural SPI controller.
module tb_spi_peripheral;

  logic       clk;
  logic       rst_n;
  logic       sclk[4];
  logic       cs_n[4];
  logic       mosi[4];
  logic       tx_dv[4];
  logic [7:0] tx_byte[4];
  logic       tx_ready[4];
  logic       rx_dv[4];
  logic [7:0] rx_byte[4];
  logic       underrun[4];
  logic       miso[4];
  logic       miso_en[4];

  int         rx_cnt[4]  = '{0, 0, 0, 0};
  int         ur_cnt[4]  = '{0, 0, 0, 0};
  logic [7:0] last_rx[4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  int vec  = 0;
  int errs = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_peripheral #(.SPI_MODE(g)) u_dut (
      .i_Clk         (clk),
      .i_Rst_L       (rst_n),
      .i_TX_Byte     (tx_byte[g]),
      .i_TX_DV       (tx_dv[g]),
      .o_TX_Ready    (tx_ready[g]),
      .o_RX_DV       (rx_dv[g]),
      .o_RX_Byte     (rx_byte[g]),
      .o_TX_Underrun (underrun[g]),
      .i_SPI_Clk     (sclk[g]),
      .i_SPI_CS_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_En (miso_en[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rx_dv[k] === 1'b1) begin
        rx_cnt[k]  <= rx_cnt[k] + 1;
        last_rx[k] <= rx_byte[k];
      end
      if (underrun[k] === 1'b1) ur_cnt[k] <= ur_cnt[k] + 1;
    end
  end

  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic supply(input int m, input logic [7:0] b);
    int t = 0;
    while (tx_ready[m] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready[m] !== 1'b1) begin
      vec++;
      errs++;
      $display("FAIL supply_timeout mode%0d: tx_ready=%b required 1", m, tx_ready[m]);
    end
    tx_byte[m] = b;
    tx_dv[m]   = 1'b1;
    @(negedge clk);
    tx_dv[m]   = 1'b0;
  endtask

  task automatic cs_start(input int m);
    cs_n[m] = 1'b0;
    half();
  endtask

  task automatic cs_end(input int m);
    half();
    cs_n[m] = 1'b1;
    half();
  endtask

  // Controller side: drives nbits of tx MSB first, returns MISO bits in rx.
  task automatic xfer(input int m, input logic [7:0] tx, input int nbits,
                      output logic [7:0] rx);
    logic cpol = (m >= 2);
    logic cpha = (m == 1) || (m == 3);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = tx[i];
        half();
        rx[i]   = miso[m];
        sclk[m] = ~cpol;
        half();
        sclk[m] = cpol;
      end else begin
        sclk[m] = ~cpol;
        mosi[m] = tx[i];
        half();
        rx[i]   = miso[m];
        sclk[m] = cpol;
        half();
      end
    end
  endtask

  task automatic test_reset();
    logic [12:0] got;
    for (int m = 0; m < 4; m++) begin
      got = {tx_ready[m], rx_dv[m], underrun[m], miso[m], miso_en[m], rx_byte[m]};
      vec++;
      if (got !== {1'b1, 4'b0000, 8'h00}) begin
        errs++;
        $display("FAIL reset_state mode%0d: got %h required %h", m, got,
                 {1'b1, 4'b0000, 8'h00});
      end
    end
  endtask

  task automatic test_mode0_basic();
    logic [7:0] rx;
    int c0 = rx_cnt[0];
    supply(0, 8'hA5);
    cs_start(0);
    vec++;
    if (miso_en[0] !== 1'b1) begin
      errs++;
      $display("FAIL miso_en_active: got %b required 1", miso_en[0]);
    end
    xfer(0, 8'h3C, 8, rx);
    cs_end(0);
    vec++;
    if (rx !== 8'hA5) begin
      errs++;
      $display("FAIL m0_miso: got %h required a5", rx);
    end
    vec++;
    if (rx_cnt[0] - c0 !== 1) begin
      errs++;
      $display("FAIL m0_rx_dv_count: got %0d required 1", rx_cnt[0] - c0);
    end
    vec++;
    if (rx_byte[0] !== 8'h3C) begin
      errs++;
      $display("FAIL m0_rx_byte: got %h required 3c", rx_byte[0]);
    end
    vec++;
    if (miso_en[0] !== 1'b0) begin
      errs++;
      $display("FAIL miso_en_idle: got %b required 0", miso_en[0]);
    end
  endtask

  task automatic test_modes();
    logic [7:0] rx;
    int c;
    for (int m = 1; m < 4; m++) begin
      c = rx_cnt[m];
      supply(m, 8'hC3);
      cs_start(m);
      xfer(m, 8'hC3, 8, rx);
      cs_end(m);
      vec++;
      if (rx !== 8'hC3) begin
        errs++;
        $display("FAIL mode%0d_miso: got %h required c3", m, rx);
      end
      vec++;
      if (last_rx[m] !== 8'hC3 || rx_cnt[m] - c !== 1) begin
        errs++;
        $display("FAIL mode%0d_rx: got %h x%0d required c3 x1", m, last_rx[m], rx_cnt[m] - c);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rx;
    logic [7:0] mo[3] = '{8'h10, 8'h20, 8'h30};
    logic [7:0] nx[3] = '{8'h03, 8'h04, 8'h00};
    int c  = rx_cnt[0];
    int u  = ur_cnt[0];
    supply(0, 8'h01);
    cs_start(0);
    supply(0, 8'h02);
    for (int b = 0; b < 3; b++) begin
      xfer(0, mo[b], 8, rx);
      vec++;
      if (rx !== 8'(b + 1) || last_rx[0] !== mo[b]) begin
        errs++;
        $display("FAIL b2b_byte%0d: got miso %h rx %h required %h %h", b, rx, last_rx[0],
                 8'(b + 1), mo[b]);
      end
      if (b < 2) supply(0, nx[b]);
    end
    cs_end(0);
    vec++;
    if (rx_cnt[0] - c !== 3) begin
      errs++;
      $display("FAIL b2b_rx_dv_count: got %0d required 3", rx_cnt[0] - c);
    end
    vec++;
    if (ur_cnt[0] - u !== 0) begin
      errs++;
      $display("FAIL b2b_underrun: got %0d required 0", ur_cnt[0] - u);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] rx0, rx1;
    int u = ur_cnt[1];
    cs_start(1);
    xfer(1, 8'h55, 8, rx0);
    xfer(1, 8'hAA, 8, rx1);
    cs_end(1);
    vec++;
    if (rx0 !== 8'hFF || rx1 !== 8'hFF) begin
      errs++;
      $display("FAIL underrun_miso: got %h %h required ff ff", rx0, rx1);
    end
    vec++;
    if (ur_cnt[1] - u !== 2) begin
      errs++;
      $display("FAIL underrun_pulses: got %0d required 2", ur_cnt[1] - u);
    end
    vec++;
    if (last_rx[1] !== 8'hAA) begin
      errs++;
      $display("FAIL underrun_rx: got %h required aa", last_rx[1]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int c = rx_cnt[0];
    cs_start(0);
    supply(0, 8'h5A);
    xfer(0, 8'hF8, 5, rx);
    cs_end(0);
    vec++;
    if (rx_cnt[0] - c !== 0) begin
      errs++;
      $display("FAIL abort_no_rx_dv: got %0d required 0", rx_cnt[0] - c);
    end
    cs_start(0);
    xfer(0, 8'h81, 8, rx);
    cs_end(0);
    vec++;
    if (rx_byte[0] !== 8'h81 || rx_cnt[0] - c !== 1) begin
      errs++;
      $display("FAIL abort_next_byte: got %h x%0d required 81 x1", rx_byte[0], rx_cnt[0] - c);
    end
    vec++;
    if (rx !== 8'h5A) begin
      errs++;
      $display("FAIL abort_hold_kept: got %h required 5a", rx);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  rx;
    logic [12:0] got;
    int c;
    supply(0, 8'h77);
    cs_start(0);
    supply(0, 8'h88);
    xfer(0, 8'hE0, 3, rx);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {tx_ready[0], rx_dv[0], underrun[0], miso[0], miso_en[0], rx_byte[0]};
    vec++;
    if (got !== {1'b1, 4'b0000, 8'h00}) begin
      errs++;
      $display("FAIL reset_mid_outputs: got %h required %h", got, {1'b1, 4'b0000, 8'h00});
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    c = rx_cnt[0];
    repeat (20) @(negedge clk);
    vec++;
    if (miso_en[0] !== 1'b0) begin
      errs++;
      $display("FAIL reset_no_restart: got miso_en %b required 0", miso_en[0]);
    end
    cs_n[0] = 1'b1;
    half();
    supply(0, 8'h96);
    cs_start(0);
    xfer(0, 8'h69, 8, rx);
    cs_end(0);
    vec++;
    if (rx !== 8'h96 || last_rx[0] !== 8'h69 || rx_cnt[0] - c !== 1) begin
      errs++;
      $display("FAIL reset_next_xfer: got miso %h rx %h x%0d required 96 69 x1", rx,
               last_rx[0], rx_cnt[0] - c);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int m = 0; m < 4; m++) begin
      sclk[m]    = (m >= 2);
      cs_n[m]    = 1'b1;
      mosi[m]    = 1'b0;
      tx_dv[m]   = 1'b0;
      tx_byte[m] = 8'h00;
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_mode0_basic();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
